// File: rtl/fsm_pkg.sv
// Shared definitions for the FSM output-code monitor: legal codes, state indices,
// control bundle and the reference next-state function.
package fsm_pkg;

  localparam int unsigned CODE_W  = 9;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned CNT_W   = 8;

  // Output code layout: {out1[2:0], out2[2:0], even, odd, terminal}
  localparam logic [CODE_W-1:0] CODE_FIRST  = 9'b011_010_1_0_0;
  localparam logic [CODE_W-1:0] CODE_SECOND = 9'b101_100_0_1_0;
  localparam logic [CODE_W-1:0] CODE_THIRD  = 9'b010_111_1_0_0;
  localparam logic [CODE_W-1:0] CODE_FOURTH = 9'b110_011_0_1_0;
  localparam logic [CODE_W-1:0] CODE_FIFTH  = 9'b101_010_1_0_1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [IDX_W-1:0] {
    ST_FIRST   = 3'd0,
    ST_SECOND  = 3'd1,
    ST_THIRD   = 3'd2,
    ST_FOURTH  = 3'd3,
    ST_FIFTH   = 3'd4,
    ST_ILLEGAL = 3'd7
  } state_idx_e;

  typedef struct packed {
    logic restart;
    logic pause;
    logic goto_third;
  } ctrl_t;

  // Reference behaviour of the monitored FSM.
  function automatic state_idx_e next_state(input state_idx_e cur, input ctrl_t ctrl);
    state_idx_e nxt;
    nxt = ST_ILLEGAL;
    case (cur)
      ST_FIRST:  nxt = (ctrl.restart || ctrl.pause) ? ST_FIRST : ST_SECOND;
      ST_SECOND: nxt = ctrl.restart ? ST_FIRST : (ctrl.pause ? ST_SECOND : ST_THIRD);
      ST_THIRD:  nxt = ctrl.restart ? ST_FIRST : (ctrl.pause ? ST_THIRD : ST_FOURTH);
      ST_FOURTH: nxt = ctrl.restart ? ST_FIRST : (ctrl.pause ? ST_FOURTH : ST_FIFTH);
      ST_FIFTH:  nxt = ctrl.goto_third ? ST_THIRD : (ctrl.restart ? ST_FIRST : ST_FIFTH);
      default:   nxt = ST_ILLEGAL;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/fsm_code_decode.sv
// Combinational decode of a 9-bit FSM output code into its state index.
module fsm_code_decode
  import fsm_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output state_idx_e        o_idx_c
);

  always_comb begin
    o_idx_c = ST_ILLEGAL;
    case (i_code)
      CODE_FIRST:  o_idx_c = ST_FIRST;
      CODE_SECOND: o_idx_c = ST_SECOND;
      CODE_THIRD:  o_idx_c = ST_THIRD;
      CODE_FOURTH: o_idx_c = ST_FOURTH;
      CODE_FIFTH:  o_idx_c = ST_FIFTH;
      default:     o_idx_c = ST_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/fsm_monitor.sv
// Watches an FSM's output code and controls, flags illegal codes and illegal
// transitions, and keeps lap / error counters.
module fsm_monitor
  import fsm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              pause,
  input  logic              goto_third,
  input  logic [2:0]        out1,
  input  logic [2:0]        out2,
  input  logic              even,
  input  logic              odd,
  input  logic              terminal,
  input  logic              clr,
  output logic [IDX_W-1:0]  state_idx,
  output logic              code_err,
  output logic              trans_err,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  lap_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  logic [CODE_W-1:0] w_code;
  ctrl_t             w_ctrl;
  state_idx_e        w_dec_c;
  state_idx_e        w_expected;
  logic              w_check;
  logic              w_code_err;
  logic              w_trans_err;
  logic              w_lap;

  state_idx_e        r_state_idx;
  ctrl_t             r_ctrl;
  logic              r_valid;
  logic              r_code_err;
  logic              r_trans_err;
  logic              r_err_sticky;
  logic [CNT_W-1:0]  r_lap_cnt;
  logic [CNT_W-1:0]  r_err_cnt;

  assign w_code = {out1, out2, even, odd, terminal};
  assign w_ctrl = '{restart: restart, pause: pause, goto_third: goto_third};

  fsm_code_decode u_decode (
    .i_code  (w_code),
    .o_idx_c (w_dec_c)
  );

  // Transition check only runs when the previous sample was a known state.
  always_comb begin
    w_expected  = next_state(r_state_idx, r_ctrl);
    w_check     = r_valid && (r_state_idx != ST_ILLEGAL);
    w_code_err  = (w_dec_c == ST_ILLEGAL);
    w_trans_err = !w_code_err && w_check && (w_dec_c != w_expected);
    w_lap       = !w_code_err && !w_trans_err && w_check &&
                  (r_state_idx == ST_FOURTH) && (w_dec_c == ST_FIFTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_idx  <= ST_FIRST;
      r_ctrl       <= '0;
      r_valid      <= 1'b0;
      r_code_err   <= 1'b0;
      r_trans_err  <= 1'b0;
      r_err_sticky <= 1'b0;
      r_lap_cnt    <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_state_idx <= w_dec_c;
      r_ctrl      <= w_ctrl;
      r_valid     <= 1'b1;
      r_code_err  <= w_code_err;
      r_trans_err <= w_trans_err;
      // clr wins over any same-cycle count/sticky update; pulses are unaffected.
      if (clr) begin
        r_err_sticky <= 1'b0;
        r_lap_cnt    <= '0;
        r_err_cnt    <= '0;
      end else begin
        if (w_code_err || w_trans_err) begin
          r_err_sticky <= 1'b1;
          if (r_err_cnt != CNT_MAX) r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
        if (w_lap && (r_lap_cnt != CNT_MAX)) r_lap_cnt <= r_lap_cnt + CNT_W'(1);
      end
    end
  end

  assign state_idx  = IDX_W'(r_state_idx);
  assign code_err   = r_code_err;
  assign trans_err  = r_trans_err;
  assign err_sticky = r_err_sticky;
  assign lap_cnt    = r_lap_cnt;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_fsm_monitor.sv
// Scoreboard bench for fsm_monitor: directed code/control vectors with
// hand-computed expectations, checked one cycle after each sample edge.
module tb_fsm_monitor;

  localparam logic [8:0] C_FIRST  = 9'b011010100;
  localparam logic [8:0] C_SECOND = 9'b101100010;
  localparam logic [8:0] C_THIRD  = 9'b010111100;
  localparam logic [8:0] C_FOURTH = 9'b110011010;
  localparam logic [8:0] C_FIFTH  = 9'b101010101;
  localparam logic [8:0] C_BAD    = 9'b111111111;

  // control encodings {restart, pause, goto_third}
  localparam logic [2:0] K_NONE = 3'b000;
  localparam logic [2:0] K_GOTO = 3'b001;
  localparam logic [2:0] K_PAUS = 3'b010;
  localparam logic [2:0] K_RST  = 3'b100;
  localparam logic [2:0] K_RP   = 3'b110;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       restart, pause, goto_third;
  logic [2:0] out1, out2;
  logic       even, odd, terminal;
  logic       clr;
  logic [2:0] state_idx;
  logic       code_err, trans_err, err_sticky;
  logic [7:0] lap_cnt, err_cnt;

  typedef struct {
    int         id;
    logic [2:0] idx;
    logic       cerr;
    logic       terr;
    logic [7:0] lap;
    logic [7:0] errc;
    logic       sticky;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   step_id = 0;

  always #5 clk = ~clk;

  fsm_monitor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart    (restart),
    .pause      (pause),
    .goto_third (goto_third),
    .out1       (out1),
    .out2       (out2),
    .even       (even),
    .odd        (odd),
    .terminal   (terminal),
    .clr        (clr),
    .state_idx  (state_idx),
    .code_err   (code_err),
    .trans_err  (trans_err),
    .err_sticky (err_sticky),
    .lap_cnt    (lap_cnt),
    .err_cnt    (err_cnt)
  );

  // Drive one sample's inputs, queue its expected result, and move to the next negedge.
  task automatic step(input logic [8:0] code, input logic [2:0] ctl, input logic cl,
                      input logic [2:0] ei, input logic ec, input logic et,
                      input logic [7:0] el, input logic [7:0] ee, input logic es);
    exp_t e;
    {out1, out2, even, odd, terminal} = code;
    {restart, pause, goto_third} = ctl;
    clr = cl;
    step_id++;
    e.id = step_id; e.idx = ei; e.cerr = ec; e.terr = et;
    e.lap = el; e.errc = ee; e.sticky = es;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_reset(input string name);
    total++;
    if ({state_idx, code_err, trans_err, err_sticky, lap_cnt, err_cnt} != 22'd0) begin
      bad++;
      $display("FAIL %s: got idx=%0d cerr=%0b terr=%0b sticky=%0b lap=%0d err=%0d, want all zero",
               name, state_idx, code_err, trans_err, err_sticky, lap_cnt, err_cnt);
    end
  endtask

  // Monitor: every sample edge produces one output set to compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        total++;
        if (state_idx !== e.idx || code_err !== e.cerr || trans_err !== e.terr ||
            lap_cnt !== e.lap || err_cnt !== e.errc || err_sticky !== e.sticky) begin
          bad++;
          $display("FAIL step%0d: got idx=%0d cerr=%0b terr=%0b lap=%0d err=%0d sticky=%0b, want idx=%0d cerr=%0b terr=%0b lap=%0d err=%0d sticky=%0b",
                   e.id, state_idx, code_err, trans_err, lap_cnt, err_cnt, err_sticky,
                   e.idx, e.cerr, e.terr, e.lap, e.errc, e.sticky);
        end
      end
    end
  end

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ecnt;
    rst_n = 1'b0;
    {out1, out2, even, odd, terminal} = C_FOURTH;
    {restart, pause, goto_third} = K_NONE;
    clr = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset_initial");
    rst_n = 1'b1;

    // Straight lap, then FIFTH->THIRD via goto_third
    step(C_FIRST,  K_NONE, 0, 3'd0, 0, 0, 8'd0, 8'd0, 0);
    step(C_SECOND, K_NONE, 0, 3'd1, 0, 0, 8'd0, 8'd0, 0);
    step(C_THIRD,  K_NONE, 0, 3'd2, 0, 0, 8'd0, 8'd0, 0);
    step(C_FOURTH, K_NONE, 0, 3'd3, 0, 0, 8'd0, 8'd0, 0);
    step(C_FIFTH,  K_GOTO, 0, 3'd4, 0, 0, 8'd1, 8'd0, 0);
    step(C_THIRD,  K_NONE, 0, 3'd2, 0, 0, 8'd1, 8'd0, 0);
    step(C_FOURTH, K_NONE, 0, 3'd3, 0, 0, 8'd1, 8'd0, 0);
    step(C_FIFTH,  K_GOTO, 0, 3'd4, 0, 0, 8'd2, 8'd0, 0);
    step(C_FIRST,  K_NONE, 0, 3'd0, 0, 1, 8'd2, 8'd1, 1);
    // Illegal code, then skipped check
    step(C_BAD,    K_NONE, 0, 3'd7, 1, 0, 8'd2, 8'd2, 1);
    step(C_SECOND, K_RP,   0, 3'd1, 0, 0, 8'd2, 8'd2, 1);
    // restart beats pause at SECOND
    step(C_FIRST,  K_NONE, 0, 3'd0, 0, 0, 8'd2, 8'd2, 1);
    step(C_SECOND, K_RP,   0, 3'd1, 0, 0, 8'd2, 8'd2, 1);
    step(C_SECOND, K_NONE, 0, 3'd1, 0, 1, 8'd2, 8'd3, 1);
    // pause holds, FIFTH stays, restart from FIFTH, pause at FIRST
    step(C_THIRD,  K_PAUS, 0, 3'd2, 0, 0, 8'd2, 8'd3, 1);
    step(C_THIRD,  K_NONE, 0, 3'd2, 0, 0, 8'd2, 8'd3, 1);
    step(C_FOURTH, K_NONE, 0, 3'd3, 0, 0, 8'd2, 8'd3, 1);
    step(C_FIFTH,  K_NONE, 0, 3'd4, 0, 0, 8'd3, 8'd3, 1);
    step(C_FIFTH,  K_RST,  0, 3'd4, 0, 0, 8'd3, 8'd3, 1);
    step(C_FIRST,  K_PAUS, 0, 3'd0, 0, 0, 8'd3, 8'd3, 1);
    step(C_FIRST,  K_NONE, 0, 3'd0, 0, 0, 8'd3, 8'd3, 1);
    step(C_SECOND, K_NONE, 0, 3'd1, 0, 0, 8'd3, 8'd3, 1);

    // Error counter saturation
    ecnt = 3;
    for (int i = 0; i < 300; i++) begin
      if (ecnt < 255) ecnt++;
      step(C_BAD, K_NONE, 0, 3'd7, 1, 0, 8'd3, 8'(ecnt), 1);
    end
    step(C_FIRST,  K_NONE, 0, 3'd0, 0, 0, 8'd3, 8'd255, 1);
    step(C_THIRD,  K_NONE, 1, 3'd2, 0, 1, 8'd0, 8'd0, 0);
    step(C_FOURTH, K_NONE, 0, 3'd3, 0, 0, 8'd0, 8'd0, 0);
    step(C_FIFTH,  K_RST,  0, 3'd4, 0, 0, 8'd1, 8'd0, 0);
    step(C_FIRST,  K_NONE, 0, 3'd0, 0, 0, 8'd1, 8'd0, 0);
    step(C_SECOND, K_NONE, 0, 3'd1, 0, 0, 8'd1, 8'd0, 0);
    step(C_THIRD,  K_NONE, 0, 3'd2, 0, 0, 8'd1, 8'd0, 0);
    step(C_FOURTH, K_NONE, 0, 3'd3, 0, 0, 8'd1, 8'd0, 0);

    // Asynchronous reset mid-lap
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset("reset_midlap");
    repeat (2) @(negedge clk);
    check_reset("reset_held");
    rst_n = 1'b1;
    step(C_FIFTH,  K_NONE, 0, 3'd4, 0, 0, 8'd0, 8'd0, 0);
    step(C_FIRST,  K_NONE, 0, 3'd0, 0, 1, 8'd0, 8'd1, 1);

    for (int w = 0; w < 10 && sb_q.size() > 0; w++) begin
      @(posedge clk);
      #2;
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
